// File: rtl/hexword_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hexword_sender_pkg
// Description : Shared FSM state type and ASCII constants for hexword_sender.
// Revision    : 1.0 - initial release
// ============================================================================
package hexword_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEX  = 2'd1,
        ST_CR   = 2'd2,
        ST_LF   = 2'd3
    } state_t;

    localparam logic [7:0] c_cr         = 8'h0D;
    localparam logic [7:0] c_lf         = 8'h0A;
    localparam logic [7:0] c_digit_base = 8'h30;
    localparam logic [7:0] c_alpha_base = 8'h41;

endpackage
`default_nettype wire

// File: rtl/hexword_sender_driverascii.sv
`default_nettype none
// ============================================================================
// Module      : driverascii
// Description : Maps one nibble to its uppercase ASCII hex digit.
// Revision    : 1.0 - initial release
// ============================================================================
module driverascii
    import hexword_sender_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = c_digit_base + {4'h0, nibble};
        end else begin
            ascii = c_alpha_base + {4'h0, nibble} - 8'd10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hexword_sender.sv
`default_nettype none
// ============================================================================
// Module      : hexword_sender
// Description : Streams a word as ASCII hex digits (MSB first), optional CRLF.
// Revision    : 1.0 - initial release
// ============================================================================
module hexword_sender
    import hexword_sender_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter bit TERM_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NIBBLES-1:0]   word_in,
    input  logic                   start,
    output logic                   busy,
    output logic [7:0]             char_out,
    output logic                   char_valid,
    input  logic                   char_ready,
    output logic                   done
);

    localparam int              CW           = $clog2(NIBBLES) + 1;
    localparam int              W            = 4 * NIBBLES;
    localparam logic [CW-1:0]   c_last_digit = CW'(NIBBLES - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_shreg;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic [7:0]      w_ascii;
    logic            w_xfer;
    logic            w_accept;
    logic            w_last_digit;
    logic            w_final_xfer;

    assign w_xfer       = char_valid & char_ready;
    assign w_accept     = (r_state == ST_IDLE) & start;
    assign w_last_digit = (r_cnt == c_last_digit);
    // Final character is the last digit without a terminator, or LF with one.
    assign w_final_xfer = w_xfer & (((r_state == ST_HEX) & w_last_digit & ~TERM_EN)
                                    | (r_state == ST_LF));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_HEX;
            ST_HEX: begin
                if (w_xfer && w_last_digit) begin
                    w_state_next = TERM_EN ? ST_CR : ST_IDLE;
                end
            end
            ST_CR:   if (w_xfer) w_state_next = ST_LF;
            ST_LF:   if (w_xfer) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        char_valid = 1'b0;
        char_out   = 8'h00;
        case (r_state)
            ST_HEX: begin
                char_valid = 1'b1;
                char_out   = w_ascii;
            end
            ST_CR: begin
                char_valid = 1'b1;
                char_out   = c_cr;
            end
            ST_LF: begin
                char_valid = 1'b1;
                char_out   = c_lf;
            end
            default: begin
                char_valid = 1'b0;
                char_out   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_final_xfer;
            if (w_accept) begin
                r_shreg <= word_in;
                r_cnt   <= '0;
            end else if ((r_state == ST_HEX) && w_xfer) begin
                r_shreg <= r_shreg << 4;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign done = r_done;
    // busy covers the done cycle even though the FSM is already back in IDLE.
    assign busy = (r_state != ST_IDLE) | r_done;

    driverascii u_ascii (
        .nibble (r_shreg[W-1 -: 4]),
        .ascii  (w_ascii)
    );

endmodule
`default_nettype wire
